// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream blocks: arbiter state encoding,
// round-robin selection and a clog2 helper that never returns zero.
package axis_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Width of an index field for n items; a single item still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // First requester found scanning upward from last+1, wrapping at n (n <= 16).
    // Returns last when nothing is requesting.
    function automatic int rr_select(input logic [15:0] req, input int last, input int n);
        int   idx;
        int   sel;
        logic found;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = last + k;
            if (idx >= n) idx -= n;
            if (k <= n && !found && req[idx[3:0]]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_frame_arbiter_if.sv
// Bundled upstream (S_COUNT sources) and downstream stream signals of the arbiter.
interface axis_frame_arbiter_if #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = ((DATA_WIDTH + 7) / 8),
    parameter int USER_WIDTH = 1
);
    import axis_pkg::*;

    localparam int ID_WIDTH = clog2_min1(S_COUNT);

    logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
    logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [S_COUNT-1:0]            s_axis_tvalid;
    logic [S_COUNT-1:0]            s_axis_tready;
    logic [S_COUNT-1:0]            s_axis_tlast;
    logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [ID_WIDTH-1:0]           m_axis_tid;
    logic [USER_WIDTH-1:0]         m_axis_tuser;

    // Arbiter side: consumes the sources, drives the shared output.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        input  m_axis_tready
    );

    // Environment side: drives the sources, consumes the shared output.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer. Output and upstream ready come straight
// from flops, so no combinational path runs from m_ready to s_ready.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    logic [WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    // Fill the output entry first; spill into the skid entry only when the
    // output is held, and drain the skid entry before accepting more.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (m_ready) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (m_ready || !out_valid_q) begin
            out_valid_d = s_valid;
            if (s_valid) out_data_d = s_data;
        end else if (s_valid) begin
            skid_data_d  = s_data;
            skid_valid_d = 1'b1;
        end
    end

    // Both entries are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign s_ready = ~skid_valid_q;
    assign m_data  = out_data_q;
    assign m_valid = out_valid_q;

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: one source owns the output from grant
// until its tlast beat is accepted; beats are tagged with the source on tid.
module axis_frame_arbiter
    import axis_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int USER_WIDTH  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    axis_frame_arbiter_if.slave            bus,
    output logic                           grant_active,
    output logic [clog2_min1(S_COUNT)-1:0] grant_index
);
    localparam int ID_WIDTH = clog2_min1(S_COUNT);
    localparam int PW       = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + USER_WIDTH;

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [S_COUNT-1:0]    s_tready;
    logic                  skid_ready;
    logic                  beat_valid, beat_last, xfer;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic [USER_WIDTH-1:0] beat_user;
    logic [PW-1:0]         in_payload, out_payload;

    // Granted source's beat; keep is forced to all ones when not propagated.
    assign beat_data  = bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign beat_keep  = (KEEP_ENABLE != 0) ? bus.s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH]
                                           : {KEEP_WIDTH{1'b1}};
    assign beat_user  = bus.s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
    assign beat_last  = bus.s_axis_tlast[grant_q];
    assign beat_valid = (state_q == ST_ACTIVE) && bus.s_axis_tvalid[grant_q];
    assign xfer       = beat_valid && skid_ready;
    assign in_payload = {beat_data, beat_keep, beat_last, grant_q, beat_user};

    // Only the granted source sees ready, and only while the skid entry is free.
    always_comb begin
        s_tready = '0;
        if (state_q == ST_ACTIVE) s_tready[grant_q] = skid_ready;
    end

    // Arbitrate in IDLE; hold the grant until the tlast beat is accepted.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && |bus.s_axis_tvalid) begin
                    grant_d = ID_WIDTH'(rr_select(16'(bus.s_axis_tvalid), int'(grant_q), S_COUNT));
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                if (xfer && beat_last) state_d = ST_IDLE;
            end
        endcase
    end

    // Reset parks the last grant at S_COUNT-1 so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= ID_WIDTH'(S_COUNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    axis_skid_reg #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (in_payload),
        .s_valid (beat_valid),
        .s_ready (skid_ready),
        .m_data  (out_payload),
        .m_valid (bus.m_axis_tvalid),
        .m_ready (bus.m_axis_tready)
    );

    assign {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
            bus.m_axis_tid, bus.m_axis_tuser} = out_payload;
    assign bus.s_axis_tready = s_tready;
    assign grant_active      = (state_q == ST_ACTIVE);
    assign grant_index       = grant_q;

endmodule
